// File: rtl/debug_pkg.sv
// ---------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug snapshot path: the snapshot transmitter FSM
// state type, frame framing constants, the debug mux select encodings and the
// helper that maps a frame position onto the byte that goes out on the wire.
// ---------------------------------------------------------------------------
package debug_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 6;

  // Debug mux select encodings, in capture order.
  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_OUT = 2'b10;
  localparam logic [1:0] SEL_OP  = 2'b11;

  // Byte k of a frame built from the four snapshot fields. The checksum is the
  // XOR of the four fields; the header is a fixed marker for resynchronising
  // the receiver. Positions past the end of the frame read as zero.
  function automatic logic [7:0] frame_byte(
    input logic [2:0] k,
    input logic [7:0] f0,
    input logic [7:0] f1,
    input logic [7:0] f2,
    input logic [7:0] f3
  );
    logic [7:0] b;
    b = 8'h00;
    case (k)
      3'd0:    b = FRAME_HDR;
      3'd1:    b = f0;
      3'd2:    b = f1;
      3'd3:    b = f2;
      3'd4:    b = f3;
      3'd5:    b = f0 ^ f1 ^ f2 ^ f3;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_snapshot_tx.sv
// ---------------------------------------------------------------------------
// debug_snapshot_tx
// Host-side driver for the debug mux. On request it walks the mux select over
// all four debug fields (Ain, Bin, ALUout, ALUop), waits SETTLE cycles on each
// before latching the returned byte, then streams a 6-byte frame
// (A5, F0, F1, F2, F3, XOR checksum) over a valid/ready byte interface.
// In continuous mode a new capture begins right after each frame.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle frame request, honoured only when idle
//   cont     in   continuous mode, sampled on the checksum handshake
//   dout     in   [7:0] byte returned by the debug mux for the current dsel
//   dsel     out  [1:0] registered select driven to the debug mux
//   busy     out  high while a frame is being captured or sent
//   tx_data  out  [7:0] current frame byte
//   tx_valid out  tx_data is valid
//   tx_ready in   downstream accepts tx_data this cycle
// ---------------------------------------------------------------------------
module debug_snapshot_tx
  import debug_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] dout,
  output logic [1:0] dsel,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int                WAIT_W    = $clog2(SETTLE + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [2:0]        LAST_K    = 3'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_idx;
  logic [2:0]        r_k;
  logic [WAIT_W-1:0] r_wait;
  logic [7:0]        r_snap [4];
  logic [1:0]        r_dsel;

  logic w_sample;
  logic w_handshake;
  logic w_frameDone;

  // A field is latched on the last cycle of its settle window; the frame ends
  // on the handshake of the checksum byte.
  assign w_sample    = (r_state == CAPTURE) && (r_wait == WAIT_LAST);
  assign w_handshake = (r_state == SEND) && tx_ready;
  assign w_frameDone = w_handshake && (r_k == LAST_K);
  assign dsel        = r_dsel;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and outputs. tx_valid and tx_data depend only on registers, so
  // tx_ready never reaches them combinationally and tx_data cannot move until
  // the handshake advances k.
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        busy = 1'b1;
        if (w_sample && (r_idx == 2'd3)) begin
          w_next = SEND;
        end
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = frame_byte(r_k, r_snap[0], r_snap[1], r_snap[2], r_snap[3]);
        if (w_frameDone) begin
          w_next = cont ? CAPTURE : IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Capture/send datapath: settle counter, field index, byte index, the
  // snapshot registers and the select register. dsel moves to the next field
  // on the same edge that latches the current one, so each select value is
  // presented for exactly SETTLE cycles. It parks on SEL_OP while sending and
  // returns to SEL_A when the frame ends, whether or not a new capture follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_k    <= 3'd0;
      r_wait <= '0;
      r_dsel <= SEL_A;
      for (int i = 0; i < 4; i++) begin
        r_snap[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_dsel <= SEL_A;
          if (start) begin
            r_idx  <= 2'd0;
            r_wait <= '0;
            r_k    <= 3'd0;
          end
        end
        CAPTURE: begin
          if (w_sample) begin
            r_snap[r_idx] <= dout;
            r_wait        <= '0;
            if (r_idx == 2'd3) begin
              r_idx  <= 2'd0;
              r_k    <= 3'd0;
              r_dsel <= SEL_OP;
            end else begin
              r_idx  <= r_idx + 2'd1;
              r_dsel <= r_idx + 2'd1;
            end
          end else begin
            r_wait <= r_wait + WAIT_ONE;
          end
        end
        SEND: begin
          if (w_frameDone) begin
            r_k    <= 3'd0;
            r_idx  <= 2'd0;
            r_wait <= '0;
            r_dsel <= SEL_A;
          end else if (w_handshake) begin
            r_k <= r_k + 3'd1;
          end
        end
        default: begin
          r_idx  <= 2'd0;
          r_k    <= 3'd0;
          r_wait <= '0;
          r_dsel <= SEL_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// ---------------------------------------------------------------------------
// tb_debug_snapshot_tx
// Drives two transmitters (SETTLE=1 and SETTLE=3), each with its own model of
// the debug mux between dsel and dout. Expected frames are built from the four
// field values; expected dsel during capture is the cycle count divided by
// SETTLE. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_debug_snapshot_tx;

  logic       clk;
  logic       rst_n;
  logic       start   [2];
  logic       cont    [2];
  logic       txReady [2];
  logic [7:0] dout    [2];
  logic [1:0] dsel    [2];
  logic       busy    [2];
  logic [7:0] txData  [2];
  logic       txValid [2];
  logic [7:0] ain     [2];
  logic [7:0] bin     [2];
  logic [7:0] aluOut  [2];
  logic [7:0] aluOp   [2];

  int checks = 0;
  int errors = 0;

  // Debug mux model: select 0..3 returns Ain, Bin, ALUout, ALUop.
  function automatic logic [7:0] debugMux(input logic [1:0] sel, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] o,
                                          input logic [7:0] p);
    logic [7:0] r;
    case (sel)
      2'd0:    r = a;
      2'd1:    r = b;
      2'd2:    r = o;
      default: r = p;
    endcase
    return r;
  endfunction

  assign dout[0] = debugMux(dsel[0], ain[0], bin[0], aluOut[0], aluOp[0]);
  assign dout[1] = debugMux(dsel[1], ain[1], bin[1], aluOut[1], aluOp[1]);

  debug_snapshot_tx #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]), .dout(dout[0]),
    .dsel(dsel[0]), .busy(busy[0]), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0])
  );

  debug_snapshot_tx #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]), .dout(dout[1]),
    .dsel(dsel[1]), .busy(busy[1]), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1])
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report the failure.
  task automatic checkOutput(input string tag, input int u, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, u, obs, exp);
    end
  endtask

  // Load the four debug fields seen by one transmitter's mux.
  task automatic applyStimulus(input int u, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] o, input logic [7:0] p);
    ain[u]    = a;
    bin[u]    = b;
    aluOut[u] = o;
    aluOp[u]  = p;
  endtask

  // One-cycle start pulse; returns at the falling edge after the sampling edge.
  task automatic pulseStart(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic checkIdle(input string tag, input int u);
    checkOutput({tag, "_busy"}, u, busy[u], 0);
    checkOutput({tag, "_valid"}, u, txValid[u], 0);
    checkOutput({tag, "_dsel"}, u, dsel[u], 0);
    checkOutput({tag, "_data"}, u, txData[u], 0);
  endtask

  // Follows one frame from the falling edge right after capture begins until
  // the falling edge after the checksum handshake. readyMode: 0 always ready,
  // 1 random ready, 2 three stall cycles on byte index 2.
  task automatic receiveFrame(input int u, input int settle, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] o,
                              input logic [7:0] p, input int readyMode,
                              input bit pokeStart, input bit lateChange,
                              input logic [7:0] lateAin);
    logic [7:0] exp [6];
    logic [7:0] prevData;
    bit         prevStall;
    bit         ready;
    int         k;
    int         stalls;
    int         sendCyc;
    exp[0] = 8'hA5;
    exp[1] = a;
    exp[2] = b;
    exp[3] = o;
    exp[4] = p;
    exp[5] = a ^ b ^ o ^ p;
    for (int j = 0; j < 4 * settle; j++) begin
      checkOutput("capture_dsel", u, dsel[u], j / settle);
      checkOutput("capture_busy", u, busy[u], 1);
      checkOutput("capture_valid", u, txValid[u], 0);
      start[u] = pokeStart && (j == 1);
      if (lateChange && (j == settle)) ain[u] = lateAin;
      @(negedge clk);
    end
    start[u] = 1'b0;
    checkOutput("valid_latency", u, txValid[u], 1);
    k         = 0;
    stalls    = 0;
    sendCyc   = 0;
    prevStall = 1'b0;
    prevData  = 8'h00;
    while ((k < 6) && (sendCyc < 200)) begin
      checkOutput("send_valid", u, txValid[u], 1);
      checkOutput("send_dsel", u, dsel[u], 3);
      checkOutput("send_busy", u, busy[u], 1);
      if (prevStall) checkOutput("hold_data", u, txData[u], prevData);
      start[u] = pokeStart && (sendCyc == 1);
      case (readyMode)
        1:       ready = ($urandom_range(0, 3) != 0);
        2:       ready = !((k == 2) && (stalls < 3));
        default: ready = 1'b1;
      endcase
      txReady[u] = ready;
      if (ready) begin
        checkOutput("frame_byte", u, txData[u], exp[k]);
        k++;
      end else begin
        checkOutput("stall_data", u, txData[u], exp[k]);
        stalls++;
      end
      prevStall = !ready;
      prevData  = txData[u];
      sendCyc++;
      @(negedge clk);
    end
    start[u]   = 1'b0;
    txReady[u] = 1'b1;
    if (k < 6) checkOutput("frame_timeout", u, k, 6);
  endtask

  initial begin
    bit         found;
    int         u;
    int         settle;
    logic [7:0] ra, rb, ro, rp;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i]   = 1'b0;
      cont[i]    = 1'b0;
      txReady[i] = 1'b1;
      applyStimulus(i, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    repeat (2) @(negedge clk);
    checkIdle("reset", 0);
    checkIdle("reset", 1);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic frame, SETTLE=1");
    applyStimulus(0, 8'h03, 8'h0C, 8'h09, 8'h05);
    pulseStart(0);
    receiveFrame(0, 1, 8'h03, 8'h0C, 8'h09, 8'h05, 0, 1'b0, 1'b0, 8'h00);
    checkIdle("basic_end", 0);

    $display("[TB] backpressure on byte 0C");
    pulseStart(0);
    receiveFrame(0, 1, 8'h03, 8'h0C, 8'h09, 8'h05, 2, 1'b0, 1'b0, 8'h00);
    checkIdle("bp_end", 0);

    $display("[TB] start while busy");
    pulseStart(0);
    receiveFrame(0, 1, 8'h03, 8'h0C, 8'h09, 8'h05, 0, 1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      checkOutput("no_second_busy", 0, busy[0], 0);
      checkOutput("no_second_valid", 0, txValid[0], 0);
      @(negedge clk);
    end

    $display("[TB] continuous mode, SETTLE=3");
    applyStimulus(1, 8'h03, 8'h0C, 8'h09, 8'h05);
    cont[1] = 1'b1;
    pulseStart(1);
    receiveFrame(1, 3, 8'h03, 8'h0C, 8'h09, 8'h05, 0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1, 8'h07, 8'h0C, 8'h09, 8'h05);
    cont[1] = 1'b0;
    receiveFrame(1, 3, 8'h07, 8'h0C, 8'h09, 8'h05, 0, 1'b0, 1'b0, 8'h00);
    checkIdle("cont_end", 1);

    $display("[TB] Ain changes mid-capture");
    applyStimulus(1, 8'h03, 8'h0C, 8'h09, 8'h05);
    pulseStart(1);
    receiveFrame(1, 3, 8'h03, 8'h0C, 8'h09, 8'h05, 1, 1'b0, 1'b1, 8'h0E);
    checkIdle("late_end", 1);

    $display("[TB] reset mid-frame");
    applyStimulus(0, 8'h03, 8'h0C, 8'h09, 8'h05);
    pulseStart(0);
    found = 1'b0;
    for (int c = 0; (c < 30) && !found; c++) begin
      if (txValid[0] && (txData[0] == 8'h09)) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("reach_byte_09", 0, found, 1);
    rst_n = 1'b0;
    #1;
    checkIdle("async_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("after_reset", 0);
    pulseStart(0);
    receiveFrame(0, 1, 8'h03, 8'h0C, 8'h09, 8'h05, 0, 1'b0, 1'b0, 8'h00);
    checkIdle("reset_frame_end", 0);

    $display("[TB] randomized frames");
    for (int r = 0; r < 8; r++) begin
      u      = r % 2;
      settle = (u == 1) ? 3 : 1;
      ra     = 8'($urandom);
      rb     = 8'($urandom);
      ro     = 8'($urandom);
      rp     = 8'($urandom);
      applyStimulus(u, ra, rb, ro, rp);
      pulseStart(u);
      receiveFrame(u, settle, ra, rb, ro, rp, 1, 1'b0, 1'b0, 8'h00);
      checkIdle("rand_end", u);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_snapshot_tx.md
# debug_snapshot_tx

Host-side counterpart of the debug mux: drives the mux's 2-bit select, reads back its 8-bit debug output for all four fields (Ain, Bin, ALUout, ALUop), and captures them into a snapshot. It then streams the snapshot as a framed byte sequence over a valid/ready byte interface, for a UART or LED-scanner downstream. It sits between the debug mux and the board I/O path.

## Interface
- SETTLE, 1, cycles each select value is held before its byte is sampled; legal range ≥1.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request for one snapshot frame; honoured only when idle.
- cont  in  1  continuous mode; sampled at end of frame.
- dout  in  8  debug byte returned by the mux for the current dsel (combinational path).
- dsel  out  2  select driven to the mux; registered.
- busy  out  1  high from the cycle after an accepted start until the frame ends.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts tx_data this cycle.

## Operation
- Frame: 6 bytes, in order 8'hA5, F0, F1, F2, F3, CHK.
  - Fn is dout sampled with dsel=n.
  - CHK = F0^F1^F2^F3.
  - Bytes are passed through unmodified; no masking of upper bits.
- States:
  - IDLE: dsel=00, busy=0, tx_valid=0. start=1 → CAPTURE with idx=0, wait=0.
  - CAPTURE: dsel=idx. wait counts 0..SETTLE-1.
    - On the edge where wait==SETTLE-1, the snapshot byte F[idx] is loaded from dout, wait clears, and idx increments.
    - After idx=3 is sampled → SEND with k=0.
  - SEND: tx_valid=1, tx_data=frame byte k. On tx_valid&&tx_ready, k increments.
    - On the handshake of k=5 (CHK): cont=1 → CAPTURE (idx=0); cont=0 → IDLE.
- CHK is computed from the snapshot registers, not from live dout.
- start while busy is ignored, not queued.
- start and cont are only sampled in the states listed above.
- dout changing mid-capture: each field reflects dout at its own sample edge only.
- In SEND, dsel holds at 11. It returns to 00 in IDLE and on capture restart.

## Timing
- Reset values: dsel=00, busy=0, tx_valid=0, tx_data=00, snapshot=0, state IDLE.
- Reset asserted mid-capture or mid-send abandons the frame immediately. No partial frame resumes after reset.
- start sampled high at edge T:
  - busy=1 and dsel=00 from T+1.
  - dsel advances every SETTLE cycles.
  - The last field is sampled at edge T+4·SETTLE.
  - tx_valid rises at T+4·SETTLE+1 with tx_data=A5.
- With tx_ready held high, one byte is sent per cycle: 6 cycles of tx_valid.
- busy falls the cycle after the CHK handshake (cont=0).
- With cont=1, the next capture starts with dsel=00 the cycle after the CHK handshake. busy stays 1 and there is a 4·SETTLE-cycle gap with tx_valid=0.
- Handshake rules:
  - tx_valid, once high, stays high until the frame ends.
  - tx_data is stable while tx_valid&&!tx_ready.
  - No combinational path from tx_ready to tx_valid or tx_data.
- Wait counter width is $clog2(SETTLE+1). idx is 2 bits, k is 3 bits; neither wraps within a frame.

## Structure
- Shared package debug_pkg holds:
  - state enum {IDLE, CAPTURE, SEND};
  - FRAME_HDR=8'hA5;
  - FRAME_LEN=6;
  - select encodings SEL_A=00, SEL_B=01, SEL_OUT=10, SEL_OP=11.
- Single module; no sub-module needed.
- Bench connects the existing debug mux between dsel and dout.

## Test plan
- Basic frame:
  - Stimulus: SETTLE=1, Ain=3, Bin=C, ALUout=9, ALUop=5, tx_ready=1, start pulse.
  - Required: frame A5 03 0C 09 05 03; tx_valid asserted 5 cycles after start edge; busy low after CHK.
- Backpressure:
  - Stimulus: tx_ready low for 3 cycles while byte 0C is presented.
  - Required: tx_data holds 0C with tx_valid=1 throughout; frame completes unchanged.
- Start while busy:
  - Stimulus: start pulses during CAPTURE and during SEND.
  - Required: exactly one frame emitted; no second frame afterwards.
- Continuous mode with SETTLE=3:
  - Stimulus: cont=1; change Ain to 7 after the first frame.
  - Required: each dsel value held 3 cycles; second frame A5 07 0C 09 05 07 starts 12 cycles after the first CHK handshake.
- Reset mid-frame:
  - Stimulus: rst_n low while byte 09 is on tx_data, then release and pulse start.
  - Required: all outputs at reset values immediately; new frame starts with A5.
- Mid-capture input change:
  - Stimulus: Ain changes from 3 to E while dsel=01.
  - Required: F0=03; CHK reflects F0=03.
